// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the parametrised non-restoring divider.
//   state_t   - controller states (IDLE, CALC, FIX, DONE)
//   cnt_width - width of the iteration counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The counter is loaded with WIDTH, so it needs $clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// div_nr_step: one combinational non-restoring division iteration.
//   p       in  WIDTH+1  partial remainder (two's complement)
//   q       in  WIDTH    quotient / dividend shift register
//   divisor in  WIDTH+1  divisor magnitude, zero-extended
//   p_next  out WIDTH+1  partial remainder after shift and add/subtract
//   q_next  out WIDTH    quotient after shift, new bit in LSB
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] p_shift;

    // The true value of 2P+bit needs WIDTH+2 bits, but the result after the
    // add/subtract always lies in [-D, D), so wrapping modulo 2^(WIDTH+1)
    // still produces the exact partial remainder.
    always_comb begin
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        p_next  = p[WIDTH] ? (p_shift + divisor) : (p_shift - divisor);
        q_next  = {q[WIDTH-2:0], ~p_next[WIDTH]};
    end

endmodule

// File: rtl/div_nr_param.sv
// div_nr_param: sequential non-restoring divider, signed or unsigned per op.
//   clk        in   rising-edge clock
//   nrst       in   synchronous active-low reset
//   start      in   request, accepted only in IDLE
//   is_signed  in   1 = two's-complement operands (sampled with start)
//   opA        in   dividend (sampled with start)
//   opB        in   divisor  (sampled with start)
//   busy       out  high from the cycle after acceptance through DONE
//   done       out  one-cycle pulse when quot/rem/dbz are updated
//   quot       out  quotient, truncated toward zero
//   rem        out  remainder, sign of the dividend
//   dbz        out  divide-by-zero flag for the last result
// Latency is a fixed WIDTH+2 cycles from acceptance to done.
module div_nr_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state, state_nxt;
    logic               busy_nxt, done_nxt;

    logic [WIDTH:0]     p_reg, div_reg, p_step;
    logic [WIDTH-1:0]   q_reg, q_step;
    logic [WIDTH-1:0]   a_raw, a_mag, b_mag, rem_mag;
    logic               q_neg, r_neg, dbz_n;
    logic [CNT_W-1:0]   cnt;

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .p       (p_reg),
        .q       (q_reg),
        .divisor (div_reg),
        .p_next  (p_step),
        .q_next  (q_step)
    );

    // Operand magnitudes; -MIN wraps to MIN, which read unsigned is 2^(WIDTH-1).
    // The final remainder restore only needs the low WIDTH bits.
    always_comb begin
        a_mag   = (is_signed && opA[WIDTH-1]) ? -opA : opA;
        b_mag   = (is_signed && opB[WIDTH-1]) ? -opB : opB;
        rem_mag = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + div_reg[WIDTH-1:0])
                               : p_reg[WIDTH-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                    busy_nxt  = 1'b1;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!nrst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well so a reset mid-operation
        // leaves no stale result or operand visible.
        if (!nrst) begin
            p_reg   <= '0;
            q_reg   <= '0;
            div_reg <= '0;
            a_raw   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dbz_n   <= 1'b0;
            cnt     <= '0;
            quot    <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg   <= a_mag;
                        div_reg <= {1'b0, b_mag};
                        p_reg   <= '0;
                        a_raw   <= opA;
                        q_neg   <= is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        r_neg   <= is_signed & opA[WIDTH-1];
                        dbz_n   <= (opB == '0);
                        cnt     <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    p_reg <= p_step;
                    q_reg <= q_step;
                    cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    if (dbz_n) begin
                        quot <= '1;
                        rem  <= a_raw;
                        dbz  <= 1'b1;
                    end else begin
                        quot <= q_neg ? -q_reg : q_reg;
                        rem  <= r_neg ? -rem_mag : rem_mag;
                        dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr_param.sv
// Self-checking bench for div_nr_param (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences and random ops against a model.
module tb_div_nr_param;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] opA, opB;
    logic         busy, done, dbz;
    logic [W-1:0] quot, rem;

    int n_tests = 0;
    int n_fail  = 0;

    div_nr_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .is_signed (is_signed),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with SV's truncating / and %.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issue one op, wait for done (bounded), return results and timing facts.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output logic busy1, output logic busy_after);
        @(negedge clk);
        opA = a; opB = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        q = quot; r = rem; z = dbz;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic do_checked(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic ez);
        logic [W-1:0] q, r;
        logic z, b1, b2;
        int lat;
        run_op(a, b, s, q, r, z, lat, b1, b2);
        check({name, " quot"}, q, eq);
        check({name, " rem"}, r, er);
        check({name, " dbz"}, z, ez);
        check({name, " latency"}, lat, LAT);
        check({name, " busy first"}, b1, 1'b1);
        check({name, " busy after"}, b2, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mq, mr, q, r;
        logic rs, mz, z, b1, b2;
        int lat, cyc, pulses;

        nrst = 1'b0; start = 1'b0; is_signed = 1'b0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quot", quot, '0);
        check("reset rem", rem, '0);
        check("reset dbz", dbz, 1'b0);
        nrst = 1'b1;

        vecs[0]  = '{32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2]  = '{32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF,   32'd1,          1'b0};
        vecs[3]  = '{32'hFFFFFFFF,   32'd2,          1'b1, 32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
        vecs[6]  = '{32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[7]  = '{32'd0,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[8]  = '{32'd1000,       32'hFFFFFFFD,   1'b1, 32'hFFFFFEB3,   32'd1,          1'b0};
        vecs[9]  = '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0};
        vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0};

        for (int i = 0; i < 11; i++) begin
            do_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                       vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // start pulsed at cycles 5 and 33 of a busy op must be ignored.
        @(negedge clk);
        opA = 32'd12345; opB = 32'd67; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opA = 32'hDEAD0000; opB = 32'd3; is_signed = 1'b1;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 5 || cyc == 33);
        end
        start = 1'b0;
        check("ignore quot", quot, 32'd184);
        check("ignore rem", rem, 32'd17);
        check("ignore latency", cyc, LAT);
        repeat (2) @(negedge clk);
        check("ignore no relaunch", busy, 1'b0);

        // start held high through DONE: next op launches in the following IDLE cycle.
        @(negedge clk);
        opA = 32'hFFFFFF9C; opB = 32'd7; is_signed = 1'b1; start = 1'b1;
        @(negedge clk);
        opA = 32'd1000; opB = 32'd10; is_signed = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("hold op1 quot", quot, 32'hFFFFFFF2);
        check("hold op1 rem", rem, 32'hFFFFFFFE);
        check("hold op1 latency", lat, LAT);
        @(negedge clk);
        check("hold idle busy", busy, 1'b0);
        @(negedge clk);
        check("hold relaunch busy", busy, 1'b1);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("hold op2 quot", quot, 32'd100);
        check("hold op2 rem", rem, 32'd0);
        check("hold op2 latency", lat, LAT);
        @(negedge clk);

        // Reset mid-operation: leave a nonzero dbz result first, then interrupt.
        do_checked("pre-reset 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
        @(negedge clk);
        opA = 32'd1000; opB = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset dbz", dbz, 1'b0);
        check("midreset quot", quot, '0);
        check("midreset rem", rem, '0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midreset no done", pulses, 0);
        do_checked("post-reset 1000/-3", 32'd1000, 32'hFFFFFFFD, 1'b1, 32'hFFFFFEB3, 32'd1, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = '1;
                3:       rb = -W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mq, mr, mz);
            run_op(ra, rb, rs, q, r, z, lat, b1, b2);
            check($sformatf("rand%0d quot %h/%h s%0d", i, ra, rb, rs), q, mq);
            check($sformatf("rand%0d rem", i), r, mr);
            check($sformatf("rand%0d dbz", i), z, mz);
            check($sformatf("rand%0d latency", i), lat, LAT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
